// File: rtl/uart_pkg.sv
// Shared types, constants and helpers for the UART receive path.
package uart_pkg;

  localparam int unsigned DATA_BITS = 8;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK
  } rx_state_t;

  // Expected parity bit for a data byte: even parity unless odd is set.
  function automatic logic calc_parity(input logic [DATA_BITS-1:0] data, input logic odd);
    return (^data) ^ odd;
  endfunction

endpackage

// File: rtl/uart_sync.sv
// Generic N-stage synchroniser for an asynchronous single-bit input; resets to 1 (idle line).
module uart_sync #(
  parameter int unsigned STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] ff;

  always_ff @(posedge clk) begin
    if (rst) ff <= '1;
    else     ff <= {ff[STAGES-2:0], d};
  end

  assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling, start-glitch rejection and framing-error reporting.
// Optional parity checking is enabled by defining UART_RX_PARITY_EN.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned SYNC_STAGES  = 2
`ifdef UART_RX_PARITY_EN
  ,
  parameter bit PARITY_ODD = 1'b0
`endif
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic                 i_RX,
  output logic [DATA_BITS-1:0] o_data,
  output logic                 o_valid,
  output logic                 o_frame_err,
  output logic                 o_busy
`ifdef UART_RX_PARITY_EN
  ,
  output logic                 o_parity_err
`endif
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam int unsigned IDX_W = 3;
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_BITS - 1);

  rx_state_t            state_q, state_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;
  logic [IDX_W-1:0]     idx_q, idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_d;
  logic                 valid_d, ferr_d, busy_d;
  logic                 rx_s;
  logic                 tick_half, tick_full;
`ifdef UART_RX_PARITY_EN
  logic                 par_q, par_d, perr_d;
`endif

  uart_sync #(.STAGES(SYNC_STAGES)) u_sync (
    .clk (i_clk),
    .rst (i_rst),
    .d   (i_RX),
    .q   (rx_s)
  );

  assign tick_half = (cnt_q == CNT_HALF);
  assign tick_full = (cnt_q == CNT_FULL);

  // State and datapath registers.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      o_data      <= '0;
      o_valid     <= 1'b0;
      o_frame_err <= 1'b0;
      o_busy      <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_q        <= 1'b0;
      o_parity_err <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      o_data      <= data_d;
      o_valid     <= valid_d;
      o_frame_err <= ferr_d;
      o_busy      <= busy_d;
`ifdef UART_RX_PARITY_EN
      par_q        <= par_d;
      o_parity_err <= perr_d;
`endif
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:  if (!rx_s) state_d = START;
      START: if (tick_half) state_d = rx_s ? IDLE : DATA;
      DATA: begin
        if (tick_full && idx_q == IDX_LAST) begin
`ifdef UART_RX_PARITY_EN
          state_d = PARITY;
`else
          state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: if (tick_full) state_d = STOP;
`endif
      // Leaving at mid stop bit gives half a bit of margin for a back-to-back start edge.
      STOP:  if (tick_full) state_d = rx_s ? IDLE : BREAK;
      BREAK: if (rx_s) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Counters, shift register and next values of the registered outputs.
  always_comb begin
    cnt_d   = cnt_q + CNT_W'(1);
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = o_data;
    valid_d = 1'b0;
    ferr_d  = 1'b0;
    busy_d  = (state_d != IDLE);
`ifdef UART_RX_PARITY_EN
    par_d  = par_q;
    perr_d = 1'b0;
`endif
    unique case (state_q)
      IDLE: cnt_d = '0;
      START: begin
        if (tick_half) begin
          cnt_d = '0;
          idx_d = '0;
        end
      end
      DATA: begin
        if (tick_full) begin
          cnt_d          = '0;
          shift_d[idx_q] = rx_s;
          idx_d          = idx_q + IDX_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (tick_full) begin
          cnt_d = '0;
          par_d = rx_s;
        end
      end
`endif
      STOP: begin
        if (tick_full) begin
          cnt_d = '0;
          if (!rx_s) begin
            ferr_d = 1'b1;
`ifdef UART_RX_PARITY_EN
          end else if (par_q != calc_parity(shift_q, PARITY_ODD)) begin
            perr_d = 1'b1;
`endif
          end else begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end
        end
      end
      BREAK:   cnt_d = '0;
      default: cnt_d = '0;
    endcase
  end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: bit-banged frames, event-queue reference model, per-cycle compare.
module tb_uart_rx;

  localparam int CPB  = 16;
  localparam int SYNC = 2;
`ifdef UART_RX_PARITY_EN
  localparam int PAR_BITS = 1;
`else
  localparam int PAR_BITS = 0;
`endif
  // Falling edge of start bit to strobe: synchroniser, half bit, data (+parity) and stop bits, output flop.
  localparam int LAT = SYNC + CPB / 2 + (9 + PAR_BITS) * CPB + 1;

  localparam int K_VALID = 0;
  localparam int K_FERR  = 1;
  localparam int K_PERR  = 2;

  typedef struct {
    logic [7:0] data;
    int         kind;
    int         t;
  } ev_t;

  logic       clk = 1'b0;
  logic       i_rst;
  logic       i_RX;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;
  logic       perr;

  int         cyc = 0;
  int         errors = 0;
  int         checks = 0;
  ev_t        exp_q[$];
  logic [7:0] model_data = 8'h00;
  int         last_lat = 0;

  uart_rx #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(SYNC)) dut (
    .i_clk       (clk),
    .i_rst       (i_rst),
    .i_RX        (i_RX),
    .o_data      (o_data),
    .o_valid     (o_valid),
    .o_frame_err (o_frame_err),
    .o_busy      (o_busy)
`ifdef UART_RX_PARITY_EN
    ,
    .o_parity_err(perr)
`endif
  );

`ifndef UART_RX_PARITY_EN
  assign perr = 1'b0;
`endif

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic fail(input string name, input int act, input int exp);
    checks++;
    errors++;
    $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Hold the line at one level for a full bit; called and returns at posedge+1.
  task automatic drive_bit(input logic b);
    i_RX = b;
    repeat (CPB) @(posedge clk);
    #1;
  endtask

  task automatic idle_bits(input int n);
    for (int i = 0; i < n; i++) drive_bit(1'b1);
  endtask

  // Send one frame and post the strobe the receiver must produce for it.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input bit par);
    ev_t e;
    e.data = d;
    e.t    = cyc;
    if (!stop_ok)                          e.kind = K_FERR;
    else if (PAR_BITS != 0 && par != ^d)   e.kind = K_PERR;
    else                                   e.kind = K_VALID;
    exp_q.push_back(e);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
    drive_bit(par);
`endif
    drive_bit(stop_ok);
  endtask

  // Per-cycle compare of strobes and held data against the event queue.
  task automatic monitor();
    bit  rst_pending = 1'b0;
    int  kind;
    int  lat;
    ev_t e;
    forever begin
      @(negedge clk);
      if (rst_pending) begin
        model_data = 8'h00;
        exp_q.delete();
      end
      rst_pending = i_rst;
      check("valid_ferr_exclusive", 32'(o_valid & o_frame_err), 32'd0);
      if (o_valid || o_frame_err || perr) begin
        kind = o_valid ? K_VALID : (o_frame_err ? K_FERR : K_PERR);
        if (exp_q.size() == 0) begin
          fail("unexpected_strobe", kind, -1);
        end else begin
          e   = exp_q.pop_front();
          lat = cyc - e.t;
          check("strobe_kind", 32'(kind), 32'(e.kind));
          if (lat < LAT - 1 || lat > LAT + 1) fail("strobe_latency", lat, LAT);
          else checks++;
          if (kind == K_VALID && e.kind == K_VALID) begin
            model_data = e.data;
            last_lat   = lat;
          end
        end
      end else if (exp_q.size() != 0 && cyc - exp_q[0].t > LAT + 1) begin
        fail("missed_strobe", cyc - exp_q[0].t, LAT);
        void'(exp_q.pop_front());
      end
      check("o_data", 32'(o_data), 32'(model_data));
    end
  endtask

  initial begin
    int t0;
    i_rst = 1'b1;
    i_RX  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    i_rst = 1'b0;
    check("reset_o_data", 32'(o_data), 32'h00);
    check("reset_o_valid", 32'(o_valid), 32'd0);
    check("reset_o_frame_err", 32'(o_frame_err), 32'd0);
    check("reset_o_busy", 32'(o_busy), 32'd0);
    fork
      monitor();
    join_none
    idle_bits(2);

    // Back-to-back frames.
    send_frame(8'h55, 1'b1, ^8'h55);
    send_frame(8'hA3, 1'b1, ^8'hA3);
    idle_bits(2);
    check("b2b_data", 32'(o_data), 32'hA3);
    check("b2b_latency_ok", 32'(last_lat >= LAT - 1 && last_lat <= LAT + 1), 32'd1);
    check("b2b_drained", 32'(exp_q.size()), 32'd0);

    // All-zero and all-one payloads.
    send_frame(8'h00, 1'b1, 1'b0);
    idle_bits(1);
    check("zero_data", 32'(o_data), 32'h00);
    check("zero_not_break", 32'(o_busy), 32'd0);
    send_frame(8'hFF, 1'b1, 1'b0);
    idle_bits(2);
    check("ones_data", 32'(o_data), 32'hFF);

    // Five-cycle low glitch on an idle line.
    t0   = cyc;
    i_RX = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    i_RX = 1'b1;
    check("glitch_busy_high", 32'(o_busy), 32'd1);
    while (cyc < t0 + 8 + SYNC + 2) begin
      @(posedge clk);
      #1;
    end
    check("glitch_busy_low", 32'(o_busy), 32'd0);
    idle_bits(2);
    check("glitch_data_kept", 32'(o_data), 32'hFF);

    // Framing error followed by a long break.
    send_frame(8'h3C, 1'b0, ^8'h3C);
    for (int i = 0; i < 40; i++) begin
      drive_bit(1'b0);
      if (i == 20) check("break_busy", 32'(o_busy), 32'd1);
    end
    idle_bits(2);
    check("break_data_kept", 32'(o_data), 32'hFF);
    check("break_busy_low", 32'(o_busy), 32'd0);
    send_frame(8'h81, 1'b1, ^8'h81);
    idle_bits(2);
    check("after_break_data", 32'(o_data), 32'h81);

    // Reset pulse in the middle of data bit 4 of 0x77.
    drive_bit(1'b0);
    for (int i = 0; i < 4; i++) drive_bit(1'b1 & ((8'h77 >> i) & 8'h01) != 0);
    i_RX = 1'b1;
    repeat (CPB / 2) @(posedge clk);
    #1;
    i_rst = 1'b1;
    @(posedge clk);
    #1;
    i_rst = 1'b0;
    idle_bits(12);
    check("abort_data_cleared", 32'(o_data), 32'h00);
    check("abort_busy_low", 32'(o_busy), 32'd0);
    send_frame(8'h12, 1'b1, ^8'h12);
    idle_bits(2);
    check("after_abort_data", 32'(o_data), 32'h12);

`ifdef UART_RX_PARITY_EN
    // Even parity: 0x07 needs parity bit 1.
    send_frame(8'h07, 1'b1, 1'b1);
    idle_bits(2);
    check("parity_good_data", 32'(o_data), 32'h07);
    send_frame(8'h07, 1'b1, 1'b0);
    idle_bits(2);
    check("parity_bad_data_kept", 32'(o_data), 32'h07);
`endif

    idle_bits(2);
    check("final_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
